// File: rtl/qmult_acc_if.sv
// Stream/handshake bundle between a qmult_acc and its driver.
`timescale 1ns/1ps
interface qmult_acc_if #(
    parameter int N     = 32,
    parameter int CNT_W = 8
);
    logic             i_start;
    logic [CNT_W-1:0] i_len;
    logic [N-1:0]     i_product;
    logic             i_valid;
    logic             o_ready;
    logic [N-1:0]     o_sum;
    logic             o_done;
    logic             o_overflow;

    modport master (
        output i_start, i_len, i_product, i_valid,
        input  o_ready, o_sum, o_done, o_overflow
    );

    modport slave (
        input  i_start, i_len, i_product, i_valid,
        output o_ready, o_sum, o_done, o_overflow
    );
endinterface

// File: rtl/qmult_acc.sv
// Sign-magnitude fixed-point accumulator for a stream of qmult products.
// Define QMULT_ACC_SAT_EN to saturate on overflow; otherwise the magnitude wraps.
`timescale 1ns/1ps
module qmult_acc #(
    parameter int Q     = 23,
    parameter int N     = 32,
    parameter int CNT_W = 8
) (
    input logic         i_clk,
    input logic         i_rst,
    qmult_acc_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [N-1:0]     ZERO_W  = {N{1'b0}};
    localparam logic [N-2:0]     ZERO_M  = {(N-1){1'b0}};
    localparam logic [CNT_W-1:0] CNT_0   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_1   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns {overflow, sign, magnitude}; -0 operands count as +0 and a zero result is +0.
    function automatic logic [N:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-2:0] ma;
        logic [N-2:0] mb;
        logic [N-2:0] mr;
        logic         sa;
        logic         sb;
        logic         sr;
        logic         ovf;
        logic [N-1:0] wide;
        ma   = a[N-2:0];
        mb   = b[N-2:0];
        sa   = a[N-1] & (|ma);
        sb   = b[N-1] & (|mb);
        ovf  = 1'b0;
        wide = ZERO_W;
        if (sa == sb) begin
            wide = {1'b0, ma} + {1'b0, mb};
            ovf  = wide[N-1];
            sr   = sa;
`ifdef QMULT_ACC_SAT_EN
            mr   = ovf ? {(N-1){1'b1}} : wide[N-2:0];
`else
            mr   = wide[N-2:0];
`endif
        end else if (ma >= mb) begin
            mr = ma - mb;
            sr = sa;
        end else begin
            mr = mb - ma;
            sr = sb;
        end
        if (mr == ZERO_M) begin
            sr = 1'b0;
        end else begin
            sr = sr;
        end
        return {ovf, sr, mr};
    endfunction

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     sum_q;
    logic [N-1:0]     sum_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             ready_q;
    logic             done_q;

    // Candidate accumulator value if the current term is accepted.
    always_comb begin
        logic [N:0] add_s;
        add_s = sm_add(sum_q, bus.i_product);
        sum_d = add_s[N-1:0];
        ovf_d = ovf_q | add_s[N];
    end

    // Control FSM; all outputs come straight from registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_0;
            sum_q   <= ZERO_W;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        sum_q <= ZERO_W;
                        ovf_q <= 1'b0;
                        cnt_q <= bus.i_len;
                        if (bus.i_len == CNT_0) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= S_ACCUM;
                            ready_q <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.i_valid) begin
                        sum_q <= sum_d;
                        ovf_q <= ovf_d;
                        cnt_q <= cnt_q - CNT_1;
                        if (cnt_q == CNT_1) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready    = ready_q;
    assign bus.o_sum      = sum_q;
    assign bus.o_done     = done_q;
    assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_qmult_acc.sv
// Directed bench for qmult_acc: integer-arithmetic model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_qmult_acc;
    localparam int N     = 32;
    localparam int CNT_W = 8;
    localparam longint MAXM = (64'sd1 <<< (N-1)) - 64'sd1;
    localparam longint MODM = (64'sd1 <<< (N-1));

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   start_cyc = 0;

    qmult_acc_if #(.N(N), .CNT_W(CNT_W)) bus ();
    qmult_acc #(.Q(23), .N(N), .CNT_W(CNT_W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Reference model: plain signed integers, advanced once per clock edge.
    longint m_acc;
    logic   m_ovf, m_active, m_fin, m_done;
    int     m_rem;

    function automatic longint sm_val(input logic [N-1:0] w);
        longint mg;
        mg = longint'(w[N-2:0]);
        return w[N-1] ? -mg : mg;
    endfunction

    function automatic logic [N-1:0] sm_enc(input longint v);
        logic [N-1:0] r;
        longint a;
        a = (v < 0) ? -v : v;
        r = N'(a);
        r[N-1] = (v < 0);
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        longint v, a;
        if (rst) begin
            m_acc = 0; m_ovf = 1'b0; m_active = 1'b0; m_fin = 1'b0; m_done = 1'b0; m_rem = 0;
        end else begin
            m_done = 1'b0;
            if (m_fin) begin
                m_done = 1'b1;
                m_fin  = 1'b0;
            end else if (!m_active) begin
                if (bus.i_start) begin
                    m_acc = 0; m_ovf = 1'b0; m_rem = int'(bus.i_len);
                    if (m_rem == 0) m_fin = 1'b1;
                    else m_active = 1'b1;
                end
            end else if (bus.i_valid) begin
                v = m_acc + sm_val(bus.i_product);
                a = (v < 0) ? -v : v;
                if (a > MAXM) begin
                    m_ovf = 1'b1;
`ifdef QMULT_ACC_SAT_EN
                    a = MAXM;
`else
                    a = a % MODM;
`endif
                    v = (v < 0) ? -a : a;
                end
                m_acc = v;
                m_rem--;
                if (m_rem == 0) begin
                    m_active = 1'b0;
                    m_fin    = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready", N'(bus.o_ready), N'(m_active));
            check("done", N'(bus.o_done), N'(m_done));
            check("sum", bus.o_sum, sm_enc(m_acc));
            check("overflow", N'(bus.o_overflow), N'(m_ovf));
        end
    end

    task automatic step(input logic st, input logic [CNT_W-1:0] ln,
                        input logic [N-1:0] p, input logic v);
        bus.i_start = st; bus.i_len = ln; bus.i_product = p; bus.i_valid = v;
        @(posedge clk); #1;
    endtask

    task automatic begin_run(input logic [CNT_W-1:0] ln);
        step(1'b1, ln, 32'h0000_0000, 1'b0);
        start_cyc = cyc;
    endtask

    task automatic feed(input logic [N-1:0] p);
        step(1'b0, 8'd0, p, 1'b1);
    endtask

    task automatic wait_done(input string nm, input int lat, input logic [N-1:0] s, input logic o);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (bus.o_done) seen = 1'b1;
            else step(1'b0, 8'd0, 32'h0000_0000, 1'b0);
        end
        check({nm, "_seen"}, N'(seen), 32'd1);
        check({nm, "_latency"}, N'(cyc - start_cyc), N'(lat));
        check({nm, "_sum"}, bus.o_sum, s);
        check({nm, "_ovf"}, N'(bus.o_overflow), N'(o));
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_len = 8'd0; bus.i_product = 32'h0; bus.i_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("rst_sum", bus.o_sum, 32'h0000_0000);
        check("rst_flags", {29'd0, bus.o_ready, bus.o_done, bus.o_overflow}, 32'd0);

        // Mixed signs.
        begin_run(8'd2);
        feed(32'h980C_0000);
        feed(32'h0080_0000);
        wait_done("mixed", 3, 32'h978C_0000, 1'b0);

        // Cancellation, started back-to-back in the idle cycle after DONE.
        begin_run(8'd2);
        feed(32'h0080_0000);
        feed(32'h8080_0000);
        wait_done("cancel", 3, 32'h0000_0000, 1'b0);

        // Overflow.
        begin_run(8'd2);
        feed(32'h7F80_0000);
        feed(32'h0100_0000);
`ifdef QMULT_ACC_SAT_EN
        wait_done("ovf", 3, 32'h7FFF_FFFF, 1'b1);
`else
        wait_done("ovf", 3, 32'h0080_0000, 1'b1);
`endif

        // Stall pattern 1,0,0,1,1 with a stray start during the gap.
        begin_run(8'd3);
        feed(32'h0040_0000);
        step(1'b1, 8'd9, 32'h0040_0000, 1'b0);
        step(1'b0, 8'd0, 32'h0040_0000, 1'b0);
        feed(32'h0040_0000);
        feed(32'h0040_0000);
        wait_done("stall", 6, 32'h00C0_0000, 1'b0);

        // Zero-length run.
        step(1'b0, 8'd0, 32'h0000_0000, 1'b0);
        begin_run(8'd0);
        wait_done("len0", 1, 32'h0000_0000, 1'b0);

        // Valid terms in IDLE are dropped; -0 input counts as +0.
        step(1'b0, 8'd0, 32'h7F00_0000, 1'b1);
        step(1'b0, 8'd0, 32'h7F00_0000, 1'b1);
        check("idle_valid_sum", bus.o_sum, 32'h0000_0000);
        begin_run(8'd3);
        feed(32'h8000_0000);
        feed(32'h8120_0000);
        feed(32'h0020_0000);
        wait_done("negzero", 4, 32'h8100_0000, 1'b0);

        // Asynchronous abort after one of four terms.
        begin_run(8'd4);
        feed(32'h0040_0000);
        check("pre_abort_sum", bus.o_sum, 32'h0040_0000);
        #2 rst = 1'b1;
        #1;
        check("abort_sum", bus.o_sum, 32'h0000_0000);
        check("abort_flags", {29'd0, bus.o_ready, bus.o_done, bus.o_overflow}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) step(1'b0, 8'd0, 32'h0000_0000, 1'b0);
        begin_run(8'd1);
        feed(32'h0080_0000);
        wait_done("after_abort", 2, 32'h0080_0000, 1'b0);

        step(1'b0, 8'd0, 32'h0000_0000, 1'b0);
        step(1'b0, 8'd0, 32'h0000_0000, 1'b0);
        check("hold_sum", bus.o_sum, 32'h0080_0000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
